vga_rect_compositor: RTL
========================

// Module: vga_rect_compositor
// PURPOSE
//   Parametrised multi-rectangle overlay for the VGA path. Takes pixel coordinates and
//   HS/VS from the vga timing block. Composites N_RECT run-time-programmable coloured
//   rectangles with fixed priority, and drives registered RGB outputs plus delay-matched
//   HS/VS to the pins.
//   Rectangle updates are double-buffered and take effect only at frame boundaries,
//   so no frame ever shows a partial update (no tearing).
// PARAMETERS
//   N_RECT   4    number of rectangles; index 0 = highest priority
//   COORD_W  10   width of x/y and of the rectangle corner fields
//   COLOR_W  4    bits per colour channel
//   H_ACTIVE 640  visible width; x >= H_ACTIVE outputs black
//   V_ACTIVE 480  visible height; y >= V_ACTIVE outputs black
//   BG_RGB   0    background colour, {R,G,B}, each channel COLOR_W bits
// PORTS
//   clk       in   1            pixel clock
//   rst       in   1            asynchronous reset, active-high
//   x         in   COORD_W      current pixel column from the timing block
//   y         in   COORD_W      current pixel row from the timing block
//   hs_in     in   1            HSYNC from the timing block, aligned with x/y
//   vs_in     in   1            VSYNC from the timing block, aligned with x/y
//   wr_en     in   1            one-cycle write strobe into the shadow table
//   wr_idx    in   clog2(N_RECT) rectangle to write
//   wr_sel    in   2            field: 0 = {x0,y0}; 1 = {x1,y1}; 2 = {en,R,G,B}
//   wr_data   in   2*COORD_W    field payload, LSB-aligned
//   HS        out  1            HSYNC delayed 2 cycles
//   VS        out  1            VSYNC delayed 2 cycles
//   RED       out  COLOR_W      registered red
//   GREEN     out  COLOR_W      registered green
//   BLUE      out  COLOR_W      registered blue
//   pending   out  1            shadow table holds writes not yet applied
// BEHAVIOUR
//   Reset: every shadow and active entry cleared (en = 0, all fields 0).
//     RGB = 0, HS = VS = 1, pending = 0, all pipeline stages cleared.
//   Frame tick: internal one-cycle pulse on the falling edge of vs_in (registered
//     vs_in = 1, current vs_in = 0). On the tick, active <= shadow for all entries
//     at once, and pending <= 0.
//   Writes: wr_en updates only the shadow field selected by wr_sel.
//     wr_sel = 3 is ignored. wr_idx >= N_RECT is ignored.
//     A valid write sets pending = 1 on the next cycle.
//   Write on the tick cycle: the copy uses the shadow value from before the write.
//     The write lands in the shadow and pending stays 1, so it applies next frame.
//   Hit test: inclusive bounds, x0 <= x <= x1 AND y0 <= y <= y1, unsigned.
//     en = 0, x0 > x1 or y0 > y1 means the rectangle never hits.
//   Pipeline, total latency 2 cycles from x/y to RGB:
//     S1 registers one hit bit per rectangle from the active table, plus visible =
//       (x < H_ACTIVE && y < V_ACTIVE).
//     S2 registers RGB: 0 if not visible; otherwise the colour of the lowest-index
//       rectangle that hits; otherwise BG_RGB.
//   HS and VS pass through the same 2-stage delay, so they stay aligned with RGB.
//   Colour field width: 3*COLOR_W <= 2*COORD_W is required.
//     Elaboration fails otherwise; it fails via a generate-time $error.
//   Reset mid-frame: outputs go to reset values at once. After release, the tables
//     are empty and only BG_RGB or black is shown until they are programmed.
// STRUCTURE
//   vga_pkg: rect field widths, wr_sel encodings (SEL_P0, SEL_P1, SEL_COL), RGB packing.
//   Sub-module vga_rect_hit: one instance per rectangle via generate. It compares
//     x/y against one active entry and outputs a combinational hit bit.
//   Top level holds: shadow/active tables, tick detect, S1/S2 registers, priority
//     mux, HS/VS delay.
// TESTING
//   1. Reset, no writes -> RGB = 0 outside the visible area, BG_RGB inside;
//      HS/VS equal hs_in/vs_in delayed exactly 2 cycles.
//   2. Program rect0 = (100,100)-(199,149), colour 7/0/0, en = 1; wait for the tick
//      -> RED = 7 exactly for x in 100..199 and y in 100..149, 2 cycles after the
//      matching x/y; pending falls on the tick.
//   3. Overlap: rect0 as in 2; rect1 = (150,120)-(300,200), colour 0/7/0
//      -> pixel (160,130) = 7/0/0; pixel (250,130) = 0/7/0.
//   4. Write rect0 mid-frame -> the current frame keeps the old colour; pending = 1
//      until the tick; the new colour appears from the next frame.
//   5. Write coincident with the tick -> not applied this frame; pending stays 1;
//      applied at the following tick. Also x0 = 300 > x1 = 200 -> never drawn.
//   6. Rect corner (630,470)-(700,520) -> drawn only up to x = 639 and y = 479;
//      black beyond. Async rst mid-line -> RGB = 0 and HS = VS = 1 within the same
//      cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA rectangle compositor.
// Write-field selector encodings and RGB packing helper ({R,G,B}, R in MSBs).
package vga_pkg;

    typedef enum logic [1:0] {
        SEL_P0   = 2'd0,
        SEL_P1   = 2'd1,
        SEL_COL  = 2'd2,
        SEL_NONE = 2'd3
    } wr_sel_e;

    function automatic int rgb_w(input int color_w);
        return 3 * color_w;
    endfunction

endpackage

// File: rtl/vga_rect_hit.sv
// Combinational inclusive hit test of pixel (x,y) against one rectangle.
// Ports: x/y pixel, x0/y0 and x1/y1 corners, en, hit out.
module vga_rect_hit #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               en,
    output logic               hit
);

    // Inverted corners fail one of the two bound tests, so they never hit.
    assign hit = en
               && (x0 <= x) && (x <= x1)
               && (y0 <= y) && (y <= y1);

endmodule

// File: rtl/vga_rect_compositor.sv
// Multi-rectangle overlay: double-buffered table, 2-stage RGB pipeline, HS/VS delay.
// Ports: clk/rst, x/y/hs_in/vs_in, wr_* shadow writes, HS/VS/RED/GREEN/BLUE, pending.
module vga_rect_compositor
    import vga_pkg::*;
#(
    parameter int N_RECT   = 4,
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 4,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter logic [3*COLOR_W-1:0] BG_RGB = '0,
    localparam int IDX_W   = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [1:0]           wr_sel,
    input  logic [2*COORD_W-1:0] wr_data,
    output logic                 HS,
    output logic                 VS,
    output logic [COLOR_W-1:0]   RED,
    output logic [COLOR_W-1:0]   GREEN,
    output logic [COLOR_W-1:0]   BLUE,
    output logic                 pending
);

    localparam int CW     = rgb_w(COLOR_W);
    localparam int EN_BIT = (CW < 2*COORD_W) ? CW : 2*COORD_W - 1;
    localparam logic [IDX_W:0]   N_LIM = N_RECT[IDX_W:0];
    localparam logic [COORD_W:0] H_LIM = H_ACTIVE[COORD_W:0];
    localparam logic [COORD_W:0] V_LIM = V_ACTIVE[COORD_W:0];

    if (CW > 2*COORD_W) begin : g_bad_width
        $error("colour field 3*COLOR_W does not fit in 2*COORD_W");
    end

    logic [COORD_W-1:0] sh_x0  [N_RECT];
    logic [COORD_W-1:0] sh_y0  [N_RECT];
    logic [COORD_W-1:0] sh_x1  [N_RECT];
    logic [COORD_W-1:0] sh_y1  [N_RECT];
    logic               sh_en  [N_RECT];
    logic [CW-1:0]      sh_col [N_RECT];

    logic [COORD_W-1:0] act_x0  [N_RECT];
    logic [COORD_W-1:0] act_y0  [N_RECT];
    logic [COORD_W-1:0] act_x1  [N_RECT];
    logic [COORD_W-1:0] act_y1  [N_RECT];
    logic               act_en  [N_RECT];
    logic [CW-1:0]      act_col [N_RECT];

    logic [N_RECT-1:0] hit_c;
    logic [N_RECT-1:0] hit_q;
    logic              vis_q;
    logic              hs_d1;
    logic              vs_d1;
    logic [CW-1:0]     col_pix;
    logic [CW-1:0]     rgb_q;
    logic              tick;
    logic              wr_ok;

    // vs_d1 doubles as the registered vs_in for falling-edge detection.
    assign tick  = vs_d1 & ~vs_in;
    assign wr_ok = wr_en
                && ({1'b0, wr_idx} < N_LIM)
                && (wr_sel != SEL_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_RECT; i++) begin
                sh_x0[i]  <= '0;
                sh_y0[i]  <= '0;
                sh_x1[i]  <= '0;
                sh_y1[i]  <= '0;
                sh_en[i]  <= 1'b0;
                sh_col[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            if (wr_ok) begin
                unique case (wr_sel_e'(wr_sel))
                    SEL_P0: begin
                        sh_x0[wr_idx] <= wr_data[2*COORD_W-1:COORD_W];
                        sh_y0[wr_idx] <= wr_data[COORD_W-1:0];
                    end
                    SEL_P1: begin
                        sh_x1[wr_idx] <= wr_data[2*COORD_W-1:COORD_W];
                        sh_y1[wr_idx] <= wr_data[COORD_W-1:0];
                    end
                    SEL_COL: begin
                        sh_en[wr_idx]  <= wr_data[EN_BIT];
                        sh_col[wr_idx] <= wr_data[CW-1:0];
                    end
                    default: ;
                endcase
            end
            // A write on the tick cycle wins: it missed this frame's copy.
            if (wr_ok)
                pending <= 1'b1;
            else if (tick)
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_RECT; i++) begin
                act_x0[i]  <= '0;
                act_y0[i]  <= '0;
                act_x1[i]  <= '0;
                act_y1[i]  <= '0;
                act_en[i]  <= 1'b0;
                act_col[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < N_RECT; i++) begin
                act_x0[i]  <= sh_x0[i];
                act_y0[i]  <= sh_y0[i];
                act_x1[i]  <= sh_x1[i];
                act_y1[i]  <= sh_y1[i];
                act_en[i]  <= sh_en[i];
                act_col[i] <= sh_col[i];
            end
        end
    end

    for (genvar i = 0; i < N_RECT; i++) begin : g_rect
        vga_rect_hit #(
            .COORD_W(COORD_W)
        ) u_hit (
            .x  (x),
            .y  (y),
            .x0 (act_x0[i]),
            .y0 (act_y0[i]),
            .x1 (act_x1[i]),
            .y1 (act_y1[i]),
            .en (act_en[i]),
            .hit(hit_c[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= '0;
            vis_q <= 1'b0;
            hs_d1 <= 1'b1;
            vs_d1 <= 1'b1;
        end else begin
            hit_q <= hit_c;
            vis_q <= ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
            hs_d1 <= hs_in;
            vs_d1 <= vs_in;
        end
    end

    // Walk from lowest priority up so index 0 is applied last and wins.
    always_comb begin
        col_pix = BG_RGB;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (hit_q[i])
                col_pix = act_col[i];
        end
        if (!vis_q)
            col_pix = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            HS    <= 1'b1;
            VS    <= 1'b1;
        end else begin
            rgb_q <= col_pix;
            HS    <= hs_d1;
            VS    <= vs_d1;
        end
    end

    assign RED   = rgb_q[CW-1 -: COLOR_W];
    assign GREEN = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign BLUE  = rgb_q[COLOR_W-1:0];

endmodule
